// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-side register block.
// Provides register indices, the VRAM access FSM states, the palette
// page constant and PPUCTRL bit positions.
package ppu_pkg;

   localparam int unsigned VRAM_AW = 14;
   localparam int unsigned DATA_W  = 8;

   // Register index within the 8-byte $2000 mirror
   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam logic [2:0] REG_SCROLL = 3'd5;
   localparam logic [2:0] REG_ADDR   = 3'd6;
   localparam logic [2:0] REG_DATA   = 3'd7;

   // v[13:8] value that redirects $2007 to the palette
   localparam logic [5:0] PAL_PAGE = 6'h3F;

   // PPUCTRL bit positions
   localparam int unsigned CTRL_MAP_BIT = 0;
   localparam int unsigned CTRL_INC_BIT = 2;
   localparam int unsigned CTRL_CHR_BIT = 4;
   localparam int unsigned CTRL_NMI_BIT = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACCESS  = 2'd2,
      ST_CAPTURE = 2'd3
   } vram_state_e;

endpackage

// File: rtl/ppu_vaddr.sv
// VRAM address and scroll sequencing for $2005/$2006 plus v increment.
// Ports: clock/reset; data_i write byte; scroll_wr_i / addr_wr_i register
// writes; toggle_clr_i from $2002 read; inc_en_i with step_i amount;
// v_o current VRAM address; scroll_x_o / scroll_y_o.
module ppu_vaddr
   import ppu_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [DATA_W-1:0]  data_i,
   input  logic               scroll_wr_i,
   input  logic               addr_wr_i,
   input  logic               toggle_clr_i,
   input  logic               inc_en_i,
   input  logic [VRAM_AW-1:0] step_i,
   output logic [VRAM_AW-1:0] v_o,
   output logic [DATA_W-1:0]  scroll_x_o,
   output logic [DATA_W-1:0]  scroll_y_o
);

   logic [VRAM_AW-1:0] v_q, v_d;
   logic [5:0]         t_hi_q, t_hi_d;
   logic               toggle_q, toggle_d;
   logic [DATA_W-1:0]  sx_q, sx_d, sy_q, sy_d;

   // Next-state: two-write sequencing shares one toggle; v wraps at 14 bits
   always_comb begin
      v_d      = v_q;
      t_hi_d   = t_hi_q;
      toggle_d = toggle_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      if (scroll_wr_i) begin
         if (!toggle_q) sx_d = data_i;
         else           sy_d = data_i;
         toggle_d = !toggle_q;
      end
      if (addr_wr_i) begin
         if (!toggle_q) t_hi_d = data_i[5:0];
         else           v_d    = {t_hi_q, data_i};
         toggle_d = !toggle_q;
      end
      if (inc_en_i)     v_d      = v_q + step_i;
      if (toggle_clr_i) toggle_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         v_q      <= '0;
         t_hi_q   <= '0;
         toggle_q <= 1'b0;
         sx_q     <= '0;
         sy_q     <= '0;
      end else begin
         v_q      <= v_d;
         t_hi_q   <= t_hi_d;
         toggle_q <= toggle_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
      end
   end

   assign v_o        = v_q;
   assign scroll_x_o = sx_q;
   assign scroll_y_o = sy_q;

endmodule

// File: rtl/ppu_vram_ctrl.sv
// CPU register file and VRAM port arbiter for the PPU.
// Ports: clock/reset; CPU bus (address, in, rd, we, out, lock_cpu);
// renderer (vblank, render_busy, render_addr); VRAM port (vram_addr,
// vram_in, vram_out, vram_we); palette port (pal_we, pal_idx, pal_d,
// pal_q); decoded state (chrpage, mappage, scroll_x, scroll_y, nmi).
module ppu_vram_ctrl
   import ppu_pkg::*;
#(
   parameter int unsigned INC_ROW = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [15:0]        address,
   input  logic [DATA_W-1:0]  in,
   input  logic               rd,
   input  logic               we,
   output logic [DATA_W-1:0]  out,
   output logic               lock_cpu,
   input  logic               vblank,
   input  logic               render_busy,
   input  logic [VRAM_AW-1:0] render_addr,
   output logic [VRAM_AW-1:0] vram_addr,
   input  logic [DATA_W-1:0]  vram_in,
   output logic [DATA_W-1:0]  vram_out,
   output logic               vram_we,
   output logic               pal_we,
   output logic [4:0]         pal_idx,
   output logic [5:0]         pal_d,
   input  logic [5:0]         pal_q,
   output logic               chrpage,
   output logic               mappage,
   output logic [DATA_W-1:0]  scroll_x,
   output logic [DATA_W-1:0]  scroll_y,
   output logic               nmi
);

   vram_state_e        state_q;
   logic [DATA_W-1:0]  ctrl_q, buf_q, out_q, wdata_q;
   logic               op_wr_q, vflag_q, vblank_q;
   logic [VRAM_AW-1:0] v;
   logic [VRAM_AW-1:0] step;
   logic [2:0]         reg_idx;
   logic               sel_c, data_acc_c, pal_acc_c, vram_start_c, status_rd_c;
   logic               unused_bits_c;

   // Requests are only taken in IDLE, so a request still held in CAPTURE is ignored
   assign reg_idx      = address[2:0];
   assign sel_c        = !reset && (state_q == ST_IDLE) && (address[15:13] == 3'b001) && (rd || we);
   assign data_acc_c   = sel_c && (reg_idx == REG_DATA);
   assign pal_acc_c    = data_acc_c && (v[13:8] == PAL_PAGE);
   assign vram_start_c = data_acc_c && (v[13:8] != PAL_PAGE);
   assign status_rd_c  = sel_c && !we && (reg_idx == REG_STATUS);
   assign step         = ctrl_q[CTRL_INC_BIT] ? VRAM_AW'(INC_ROW) : VRAM_AW'(1);

   ppu_vaddr u_vaddr (
      .clock        (clock),
      .reset        (reset),
      .data_i       (in),
      .scroll_wr_i  (sel_c && we && (reg_idx == REG_SCROLL)),
      .addr_wr_i    (sel_c && we && (reg_idx == REG_ADDR)),
      .toggle_clr_i (status_rd_c),
      .inc_en_i     (pal_acc_c || (state_q == ST_ACCESS)),
      .step_i       (step),
      .v_o          (v),
      .scroll_x_o   (scroll_x),
      .scroll_y_o   (scroll_y)
   );

   // Registers, vblank flag and VRAM access sequencer
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= '0;
         buf_q    <= '0;
         out_q    <= '0;
         wdata_q  <= '0;
         op_wr_q  <= 1'b0;
         vflag_q  <= 1'b0;
         vblank_q <= 1'b0;
      end else begin
         vblank_q <= vblank;
         // A vblank rise wins over a same-cycle $2002 clear
         if (vblank && !vblank_q)      vflag_q <= 1'b1;
         else if (!vblank && vblank_q) vflag_q <= 1'b0;
         else if (status_rd_c)         vflag_q <= 1'b0;

         if (sel_c && we && (reg_idx == REG_CTRL)) ctrl_q <= in;
         if (status_rd_c)            out_q <= {vflag_q, 7'b0};
         if (pal_acc_c && !we)       out_q <= {2'b00, pal_q};

         case (state_q)
            ST_IDLE: begin
               if (vram_start_c) begin
                  op_wr_q <= we;
                  wdata_q <= in;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!render_busy) state_q <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // Reads return the previous buffer and refill it
               if (!op_wr_q) begin
                  buf_q <= vram_in;
                  out_q <= buf_q;
               end
               state_q <= ST_CAPTURE;
            end
            ST_CAPTURE: state_q <= ST_IDLE;
            default:    state_q <= ST_IDLE;
         endcase
      end
   end

   // Renderer always owns the port when busy
   assign vram_addr = render_busy ? render_addr : v;
   assign vram_we   = !reset && (state_q == ST_WAIT) && !render_busy && op_wr_q;
   assign vram_out  = wdata_q;
   assign lock_cpu  = !reset && (vram_start_c || (state_q == ST_WAIT) || (state_q == ST_ACCESS));

   assign pal_we    = pal_acc_c && we;
   assign pal_idx   = v[4:0];
   assign pal_d     = in[5:0];

   assign out       = out_q;
   assign chrpage   = ctrl_q[CTRL_CHR_BIT];
   assign mappage   = ctrl_q[CTRL_MAP_BIT];
   assign nmi       = ctrl_q[CTRL_NMI_BIT] && vflag_q;

   assign unused_bits_c = ^{ctrl_q[6:5], ctrl_q[3], ctrl_q[1], address[12:3]};

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Self-checking bench for ppu_vram_ctrl: register table plus VRAM/palette
// write scoreboard and hand sequences for stall, vblank and reset cases.
module tb_ppu_vram_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address = '0;
   logic [7:0]  in = '0;
   logic        rd = 1'b0, we = 1'b0;
   logic [7:0]  out;
   logic        lock_cpu;
   logic        vblank = 1'b0;
   logic        render_busy = 1'b0;
   logic [13:0] render_addr = '0;
   logic [13:0] vram_addr;
   logic [7:0]  vram_in;
   logic [7:0]  vram_out;
   logic        vram_we;
   logic        pal_we;
   logic [4:0]  pal_idx;
   logic [5:0]  pal_d;
   logic [5:0]  pal_q;
   logic        chrpage, mappage, nmi;
   logic [7:0]  scroll_x, scroll_y;

   ppu_vram_ctrl #(.INC_ROW(32)) dut (
      .clock(clock), .reset(reset), .address(address), .in(in), .rd(rd), .we(we),
      .out(out), .lock_cpu(lock_cpu), .vblank(vblank), .render_busy(render_busy),
      .render_addr(render_addr), .vram_addr(vram_addr), .vram_in(vram_in),
      .vram_out(vram_out), .vram_we(vram_we), .pal_we(pal_we), .pal_idx(pal_idx),
      .pal_d(pal_d), .pal_q(pal_q), .chrpage(chrpage), .mappage(mappage),
      .scroll_x(scroll_x), .scroll_y(scroll_y), .nmi(nmi)
   );

   always #5 clock = ~clock;

   // VRAM and palette models: synchronous-read VRAM, async-read palette
   logic [7:0] vmem [0:16383];
   logic [5:0] palmem [0:31];
   always @(posedge clock) begin
      if (vram_we) vmem[vram_addr] <= vram_out;
      vram_in <= vmem[vram_addr];
      if (pal_we) palmem[pal_idx] <= pal_d;
   end
   assign pal_q = palmem[pal_idx];

   typedef struct packed {
      logic        pal;
      logic [13:0] addr;
      logic [7:0]  data;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [7:0]  data;
      int          stall;
      logic        chk_out;
      logic [7:0]  exp_out;
      logic [7:0]  exp_sx;
      logic [7:0]  exp_sy;
      logic        exp_chr;
      logic        exp_map;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Negedge sample: render tracking and write scoreboard
   task automatic sample();
      wr_t g, e;
      @(negedge clock);
      if (render_busy) chk("vram_addr_render", 32'(vram_addr), 32'(render_addr));
      if (vram_we || pal_we) begin
         g.pal  = pal_we;
         g.addr = pal_we ? {9'd0, pal_idx} : vram_addr;
         g.data = pal_we ? {2'b00, pal_d} : vram_out;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(g), 32'h7FFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("write", 32'(g), 32'(e));
         end
      end
   endtask

   task automatic cpu_acc(input logic [15:0] a, input logic w, input logic [7:0] d,
                          output int stall, output logic [7:0] o);
      @(posedge clock); #1;
      address = a; we = w; rd = !w; in = d; stall = 0;
      sample();
      while (lock_cpu && stall < 40) begin
         stall++;
         @(posedge clock);
         sample();
      end
      if (stall >= 40) chk("lock_timeout", 32'(stall), 32'd0);
      @(posedge clock); #1;
      address = '0; we = 1'b0; rd = 1'b0;
      sample();
      o = out;
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
      int s; logic [7:0] o;
      cpu_acc(a, 1'b1, d, s, o);
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1; rd = 1'b0; we = 1'b0; render_busy = 1'b0; vblank = 1'b0;
      sample();
      @(posedge clock); #1;
      reset = 1'b0;
      sample();
   endtask

   vec_t vecs[8];
   int   st;
   logic [7:0] o;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'h2000, 1'b1, 8'h11, 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
      vecs[1] = '{16'h2005, 1'b1, 8'h12, 0, 1'b0, 8'h00, 8'h12, 8'h00, 1'b1, 1'b1};
      vecs[2] = '{16'h2005, 1'b1, 8'h34, 0, 1'b0, 8'h00, 8'h12, 8'h34, 1'b1, 1'b1};
      vecs[3] = '{16'h3FFD, 1'b1, 8'h56, 0, 1'b0, 8'h00, 8'h56, 8'h34, 1'b1, 1'b1};
      vecs[4] = '{16'h4005, 1'b1, 8'h99, 0, 1'b0, 8'h00, 8'h56, 8'h34, 1'b1, 1'b1};
      vecs[5] = '{16'h2002, 1'b0, 8'h00, 0, 1'b1, 8'h00, 8'h56, 8'h34, 1'b1, 1'b1};
      vecs[6] = '{16'h2005, 1'b1, 8'h78, 0, 1'b0, 8'h00, 8'h78, 8'h34, 1'b1, 1'b1};
      vecs[7] = '{16'h2000, 1'b1, 8'h00, 0, 1'b0, 8'h00, 8'h78, 8'h34, 1'b0, 1'b0};

      do_reset();
      chk("rst_out", 32'(out), 32'h0);
      chk("rst_lock", 32'(lock_cpu), 32'h0);
      chk("rst_nmi", 32'(nmi), 32'h0);
      chk("rst_vram_we", 32'(vram_we), 32'h0);
      chk("rst_pal_we", 32'(pal_we), 32'h0);
      chk("rst_scroll", 32'({scroll_x, scroll_y}), 32'h0);
      chk("rst_pages", 32'({chrpage, mappage}), 32'h0);

      // Register table
      for (int i = 0; i < 8; i++) begin
         cpu_acc(vecs[i].addr, vecs[i].wr, vecs[i].data, st, o);
         chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].stall));
         if (vecs[i].chk_out) chk($sformatf("vec%0d_out", i), 32'(o), 32'(vecs[i].exp_out));
         chk($sformatf("vec%0d_sx", i), 32'(scroll_x), 32'(vecs[i].exp_sx));
         chk($sformatf("vec%0d_sy", i), 32'(scroll_y), 32'(vecs[i].exp_sy));
         chk($sformatf("vec%0d_pages", i), 32'({chrpage, mappage}), 32'({vecs[i].exp_chr, vecs[i].exp_map}));
      end

      // Basic VRAM write, then a second write proves v advanced to $2109
      do_reset();
      wr_reg(16'h2006, 8'h21);
      wr_reg(16'h2006, 8'h08);
      exp_q.push_back('{1'b0, 14'h2108, 8'h5A});
      cpu_acc(16'h2007, 1'b1, 8'h5A, st, o);
      chk("w1_stall", 32'(st), 32'd3);
      exp_q.push_back('{1'b0, 14'h2109, 8'h77});
      cpu_acc(16'h2007, 1'b1, 8'h77, st, o);
      chk("w2_stall", 32'(st), 32'd3);

      // Palette write at $3FF0, row increment wraps v to $0010
      do_reset();
      wr_reg(16'h2000, 8'h04);
      wr_reg(16'h2006, 8'h3F);
      wr_reg(16'h2006, 8'hF0);
      exp_q.push_back('{1'b1, 14'h0010, 8'h11});
      cpu_acc(16'h2007, 1'b1, 8'h11, st, o);
      chk("pal_w_stall", 32'(st), 32'd0);
      exp_q.push_back('{1'b0, 14'h0010, 8'h22});
      cpu_acc(16'h2007, 1'b1, 8'h22, st, o);
      chk("wrap_w_stall", 32'(st), 32'd3);
      wr_reg(16'h2006, 8'h3F);
      wr_reg(16'h2006, 8'h10);
      cpu_acc(16'h2007, 1'b0, 8'h00, st, o);
      chk("pal_r_stall", 32'(st), 32'd0);
      chk("pal_r_out", 32'(o), 32'h11);

      // Seed $0123, then buffered reads with the renderer busy 4 cycles
      wr_reg(16'h2000, 8'h00);
      wr_reg(16'h2006, 8'h01);
      wr_reg(16'h2006, 8'h23);
      exp_q.push_back('{1'b0, 14'h0123, 8'hC3});
      cpu_acc(16'h2007, 1'b1, 8'hC3, st, o);
      do_reset();
      wr_reg(16'h2006, 8'h01);
      wr_reg(16'h2006, 8'h23);
      fork
         cpu_acc(16'h2007, 1'b0, 8'h00, st, o);
         begin
            repeat (2) @(posedge clock);
            for (int i = 0; i < 4; i++) begin
               #1;
               render_busy = 1'b1;
               render_addr = 14'(14'h1000 + i);
               @(posedge clock);
            end
            #1;
            render_busy = 1'b0;
         end
      join
      chk("busy_r_stall", 32'(st), 32'd7);
      chk("busy_r_out", 32'(o), 32'h00);
      cpu_acc(16'h2007, 1'b0, 8'h00, st, o);
      chk("r2_stall", 32'(st), 32'd3);
      chk("r2_out", 32'(o), 32'hC3);

      // vblank rise with NMI enabled
      do_reset();
      wr_reg(16'h2000, 8'h80);
      @(posedge clock); #1;
      vblank = 1'b1;
      sample();
      chk("nmi_same_cycle", 32'(nmi), 32'd0);
      @(posedge clock);
      sample();
      chk("nmi_after_rise", 32'(nmi), 32'd1);
      cpu_acc(16'h2002, 1'b0, 8'h00, st, o);
      chk("status_r1", 32'(o), 32'h80);
      chk("nmi_cleared", 32'(nmi), 32'd0);
      cpu_acc(16'h2002, 1'b0, 8'h00, st, o);
      chk("status_r2", 32'(o), 32'h00);

      // $2002 read in the same cycle as the vblank rise
      @(posedge clock); #1;
      vblank = 1'b0;
      sample();
      @(posedge clock);
      sample();
      @(posedge clock); #1;
      vblank = 1'b1; address = 16'h2002; rd = 1'b1;
      sample();
      @(posedge clock); #1;
      rd = 1'b0; address = '0;
      sample();
      chk("race_out", 32'(out), 32'h00);
      chk("race_nmi", 32'(nmi), 32'd1);
      cpu_acc(16'h2002, 1'b0, 8'h00, st, o);
      chk("race_status_after", 32'(o), 32'h80);

      // Reset while the FSM sits in WAIT with the port free
      do_reset();
      wr_reg(16'h2006, 8'h02);
      wr_reg(16'h2006, 8'h40);
      wr_reg(16'h2006, 8'h03);
      @(posedge clock); #1;
      address = 16'h2007; we = 1'b1; in = 8'h99;
      sample();
      chk("abort_lock_accept", 32'(lock_cpu), 32'd1);
      @(posedge clock); #1;
      reset = 1'b1; we = 1'b0; address = '0;
      sample();
      @(posedge clock); #1;
      reset = 1'b0;
      sample();
      chk("abort_lock", 32'(lock_cpu), 32'd0);
      chk("abort_vram_we", 32'(vram_we), 32'd0);
      wr_reg(16'h2005, 8'hAB);
      chk("abort_toggle", 32'(scroll_x), 32'hAB);
      exp_q.push_back('{1'b0, 14'h0000, 8'h44});
      cpu_acc(16'h2007, 1'b1, 8'h44, st, o);
      chk("abort_v_stall", 32'(st), 32'd3);

      repeat (2) begin
         @(posedge clock);
         sample();
      end
      chk("pending_writes", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ppu_vram_ctrl.md
# ppu_vram_ctrl

CPU-side register file and VRAM access arbiter for the Dendy PPU. Decodes CPU accesses to $2000–$3FFF (8-register mirror), holds PPUCTRL, scroll, VRAM address and read buffer, and shares the single 14-bit VRAM port between the background renderer (absolute priority) and CPU $2007 traffic, stalling the CPU via `lock_cpu` until a free slot. It also owns the vblank status flag and NMI generation.

## Interface
- `INC_ROW`, 32: VRAM address increment when PPUCTRL bit 2 = 1 (otherwise +1).
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 16: CPU address.
- `in` in 8: CPU write data.
- `rd` in 1: CPU read request, held while `lock_cpu` = 1.
- `we` in 1: CPU write request, held while `lock_cpu` = 1; wins if `rd` is also set.
- `out` out 8: registered CPU read data.
- `lock_cpu` out 1: stall the CPU.
- `vblank` in 1: level from renderer, high during vertical blank.
- `render_busy` in 1: renderer owns the VRAM port this cycle.
- `render_addr` in 14: renderer VRAM address.
- `vram_addr` out 14: VRAM port address (muxed).
- `vram_in` in 8: VRAM read data, valid one cycle after address.
- `vram_out` out 8: VRAM write data.
- `vram_we` out 1: VRAM write strobe.
- `pal_we` out 1, `pal_idx` out 5, `pal_d` out 6: palette write port; `pal_q` in 6: palette read at `pal_idx`.
- `chrpage` out 1 (ctrl[4]), `mappage` out 1 (ctrl[0]), `scroll_x` out 8, `scroll_y` out 8, `nmi` out 1.

## Operation
- Selection: `address[15:13] == 3'b001`; register = `address[2:0]`. Other addresses ignored.
- $2000 write: ctrl ← in. `nmi` = ctrl[7] & vflag (combinational).
- $2002 read: out ← {vflag, 7'b0}; then vflag ← 0, toggle ← 0.
- vflag: set on rising edge of `vblank`, cleared on falling edge. Set in the same cycle as a $2002 read: read returns 0, flag ends at 1.
- $2005 write: toggle 0 → scroll_x ← in; toggle 1 → scroll_y ← in; toggle flips.
- $2006 write: toggle 0 → t[13:8] ← in[5:0]; toggle 1 → v ← {t[13:8], in}; toggle flips.
- $2007 with v[13:8] == 6'h3F (palette): no VRAM cycle, no stall. Write → `pal_we` pulse, `pal_idx` = v[4:0], `pal_d` = in[5:0]. Read → out ← {2'b00, pal_q}. v increments.
- $2007 otherwise: FSM IDLE → WAIT → ACCESS → CAPTURE → IDLE.
  - IDLE: on accept, latch op/data, go WAIT; `lock_cpu` = 1 combinationally in the accept cycle.
  - WAIT: stay while `render_busy`; else drive `vram_addr` = v and `vram_we` = op_write, `vram_out` = data; go ACCESS.
  - ACCESS: read → buffer ← `vram_in`, out ← old buffer; v ← v + inc; go CAPTURE.
  - CAPTURE: `lock_cpu` = 0; go IDLE. The CPU drops its request this cycle and must not be re-accepted.
- `vram_addr` = `render_addr` whenever `render_busy` = 1. The renderer is never delayed.
- inc = ctrl[2] ? `INC_ROW` : 1. v is 14-bit modulo, so $3FFF+1 → $0000.

## Timing
- Reset values: ctrl, t, v, toggle, buffer, vflag, scroll_x/y, out = 0; FSM IDLE; `lock_cpu`, `vram_we`, `pal_we`, `nmi` = 0. Reset mid-FSM aborts the access with no VRAM write and no increment.
- Non-$2007 and palette accesses: one cycle, no stall; `out` valid the cycle after accept.
- $2007 VRAM access: stall = 3 + N cycles, N = consecutive `render_busy` cycles seen in WAIT. `vram_we` is a one-cycle pulse in the WAIT-exit cycle. `out` is valid in CAPTURE.
- With the renderer's 5-of-16 fetch pattern, N ≤ 5 during paper and 0 in blanking.
- The edge detector for `vblank` is a one-cycle registered delay.

## Structure
- Shared package `ppu_pkg`: register indices (CTRL=0, STATUS=2, SCROLL=5, ADDR=6, DATA=7), FSM state enum, palette page constant 6'h3F, and PPUCTRL bit positions.
- One sub-module is natural: `ppu_vaddr`, holding v, t, toggle, the increment and $2005/$2006 sequencing.

## Test plan
- $2006 ← $21, $2006 ← $08, $2007 ← $5A with `render_busy` = 0 → single `vram_we` at $2108 with $5A; `lock_cpu` high 3 cycles; v = $2109.
- ctrl[2] = 1, v = $3FF0, two $2007 writes → VRAM writes at $3FF0 and $0010, i.e. a wrap. Because v[13:8] = $3F, the first write must go to the palette instead: `pal_we` with idx $10 and no `vram_we`. Check both.
- `render_busy` high for 4 cycles during a $2007 read → `vram_addr` tracks `render_addr` throughout; stall = 7 cycles; first read returns stale buffer ($00), second returns the byte at the first address.
- `vblank` rises with ctrl[7] = 1 → `nmi` = 1 after 1 cycle; $2002 read returns $80, then `nmi` = 0, and a second read returns $00.
- $2002 read in the exact cycle vflag is set → out = $00, `nmi` asserted next cycle.
- `reset` asserted while FSM is in WAIT → no `vram_we`, `lock_cpu` = 0 next cycle, v = 0, toggle = 0.
